// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive decoder.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    BUS_SE0 = 2'b00,
    BUS_J   = 2'b01,
    BUS_K   = 2'b10,
    BUS_SE1 = 2'b11
  } bus_state_t;

  typedef enum logic [2:0] {
    DEC_IDLE,
    DEC_SYNC,
    DEC_PAYLOAD,
    DEC_EOP,
    DEC_ABORT
  } decoder_state_t;

  localparam int OVS_FS_DEFAULT     = 4;
  localparam int OVS_LS_DEFAULT     = 32;
  localparam int STUFF_LEN_DEFAULT  = 6;
  localparam int RESET_CLKS_DEFAULT = 360000;

  // Majority of three samples; when all three differ the middle sample wins.
  function automatic bus_state_t vote3(input bus_state_t a, input bus_state_t b,
                                       input bus_state_t c);
    return (a == b || a == c) ? a : b;
  endfunction

endpackage

// File: rtl/usb_line_sync.sv
// Synchronizes the raw dp/dn pins and classifies the bus symbol.
module usb_line_sync import usb_rx_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk48,
  input  logic       reset_n,
  input  logic       dp,
  input  logic       dn,
  input  logic       ls_mode,
  output logic [1:0] line
);

  logic [SYNC_STAGES-1:0] dp_sync;
  logic [SYNC_STAGES-1:0] dn_sync;

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      dp_sync <= '0;
      dn_sync <= '0;
    end else begin
      dp_sync <= {dp_sync[SYNC_STAGES-2:0], dp};
      dn_sync <= {dn_sync[SYNC_STAGES-2:0], dn};
    end
  end

  // Low-speed idles with dn high, so J/K swap relative to full-speed.
  always_comb begin
    line = BUS_SE0;
    unique case ({dp_sync[SYNC_STAGES-1], dn_sync[SYNC_STAGES-1]})
      2'b00:   line = BUS_SE0;
      2'b11:   line = BUS_SE1;
      2'b10:   line = ls_mode ? BUS_K : BUS_J;
      default: line = ls_mode ? BUS_J : BUS_K;
    endcase
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive front end: bit recovery, NRZI decode, unstuffing, SOP/EOP/reset detection.
// state   | meaning
// IDLE    | bus idle, speed mode latched, waiting for first K
// SYNC    | sampling the sync pattern until two K symbols in a row
// PAYLOAD | decoding NRZI data bits and removing stuffed zeros
// EOP     | SE0 decided, waiting for J to close the packet
// ABORT   | error seen, waiting for SE0 then J
module usb_rx_decoder import usb_rx_pkg::*; #(
  parameter int OVS_FS      = OVS_FS_DEFAULT,
  parameter int OVS_LS      = OVS_LS_DEFAULT,
  parameter int STUFF_LEN   = STUFF_LEN_DEFAULT,
  parameter int RESET_CLKS  = RESET_CLKS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk48,
  input  logic reset_n,
  input  logic dp,
  input  logic dn,
  input  logic ls_mode,
  output logic bit_out,
  output logic bit_valid,
  output logic bus_sop,
  output logic bus_eop,
  output logic bus_reset,
  output logic stuff_err,
  output logic se1_err
);

  localparam int OVS_MAX = (OVS_FS > OVS_LS) ? OVS_FS : OVS_LS;
  localparam int PW      = $clog2(OVS_MAX);
  localparam int SW      = $clog2(STUFF_LEN + 1);
  localparam int RW      = $clog2(RESET_CLKS + 1);

  typedef logic [PW-1:0] phase_t;

  localparam phase_t LAST_FS = phase_t'(OVS_FS - 1);
  localparam phase_t LAST_LS = phase_t'(OVS_LS - 1);
  localparam phase_t V0_FS   = phase_t'(OVS_FS / 2 - 1);
  localparam phase_t V0_LS   = phase_t'(OVS_LS / 2 - 1);
  localparam phase_t V1_FS   = phase_t'(OVS_FS / 2);
  localparam phase_t V1_LS   = phase_t'(OVS_LS / 2);
  localparam phase_t DEC_FS  = phase_t'(OVS_FS / 2 + 1);
  localparam phase_t DEC_LS  = phase_t'(OVS_LS / 2 + 1);
  localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LEN);
  localparam logic [RW-1:0] RST_MAX   = RW'(RESET_CLKS);

  logic [1:0]     line_raw;
  bus_state_t     line, line_q, vote_a, vote_b, prev_sym, sym;
  decoder_state_t state;
  logic           mode_ls;
  phase_t         phase_q, phase, last, v0, v1, dpt;
  logic [SW-1:0]  ones_cnt;
  logic [RW-1:0]  se0_cnt, se0_next;
  logic           abort_se0, edge_rs, decide, bit_val;

  usb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk48   (clk48),
    .reset_n (reset_n),
    .dp      (dp),
    .dn      (dn),
    .ls_mode (mode_ls),
    .line    (line_raw)
  );

  assign line = bus_state_t'(line_raw);
  assign last = mode_ls ? LAST_LS : LAST_FS;
  assign v0   = mode_ls ? V0_LS : V0_FS;
  assign v1   = mode_ls ? V1_LS : V1_FS;
  assign dpt  = mode_ls ? DEC_LS : DEC_FS;

  // A J<->K change marks phase 0 of the current cycle and pre-empts a decision.
  assign edge_rs = (state != DEC_IDLE) &&
                   ((line == BUS_J && line_q == BUS_K) || (line == BUS_K && line_q == BUS_J));
  assign phase   = edge_rs ? '0 : phase_q;
  assign decide  = (state inside {DEC_SYNC, DEC_PAYLOAD}) && !edge_rs && (phase_q == dpt);
  assign sym     = vote3(vote_a, vote_b, line);
  assign bit_val = (sym == prev_sym);

  always_comb begin
    se0_next = '0;
    if (line == BUS_SE0)
      se0_next = (se0_cnt == RST_MAX) ? se0_cnt : se0_cnt + 1'b1;
  end

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= DEC_IDLE;
      mode_ls   <= 1'b0;
      phase_q   <= '0;
      line_q    <= BUS_SE0;
      vote_a    <= BUS_SE0;
      vote_b    <= BUS_SE0;
      prev_sym  <= BUS_SE0;
      ones_cnt  <= '0;
      se0_cnt   <= '0;
      abort_se0 <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bus_sop   <= 1'b0;
      bus_eop   <= 1'b0;
      bus_reset <= 1'b0;
      stuff_err <= 1'b0;
      se1_err   <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      bus_sop   <= 1'b0;
      bus_eop   <= 1'b0;
      stuff_err <= 1'b0;
      se1_err   <= 1'b0;
      abort_se0 <= 1'b0;
      line_q    <= line;
      se0_cnt   <= se0_next;
      bus_reset <= (se0_next == RST_MAX);
      phase_q   <= (phase == last) ? '0 : phase + 1'b1;
      if (phase == v0) vote_a <= line;
      if (phase == v1) vote_b <= line;

      case (state)
        DEC_IDLE: begin
          mode_ls <= ls_mode;
          phase_q <= '0;
          if (line == BUS_K) begin
            state    <= DEC_SYNC;
            bus_sop  <= 1'b1;
            phase_q  <= phase_t'(1);
            prev_sym <= BUS_J;
          end
        end
        DEC_SYNC: begin
          if (decide) begin
            prev_sym <= sym;
            if (sym == BUS_K && prev_sym == BUS_K) begin
              state    <= DEC_PAYLOAD;
              ones_cnt <= SW'(1);
            end else if (sym == BUS_SE0 || sym == BUS_SE1) begin
              state <= DEC_ABORT;
            end
          end
        end
        DEC_PAYLOAD: begin
          if (decide) begin
            prev_sym <= sym;
            if (sym == BUS_SE0) begin
              state <= DEC_EOP;
            end else if (sym == BUS_SE1) begin
              se1_err <= 1'b1;
              state   <= DEC_ABORT;
            end else if (ones_cnt == STUFF_MAX) begin
              if (bit_val) begin
                stuff_err <= 1'b1;
                state     <= DEC_ABORT;
              end else begin
                ones_cnt <= '0;
              end
            end else begin
              bit_valid <= 1'b1;
              bit_out   <= bit_val;
              ones_cnt  <= bit_val ? ones_cnt + 1'b1 : '0;
            end
          end
        end
        DEC_EOP: begin
          if (line == BUS_J) begin
            state   <= DEC_IDLE;
            bus_eop <= 1'b1;
          end else if (line == BUS_K) begin
            state <= DEC_ABORT;
          end
        end
        DEC_ABORT: begin
          abort_se0 <= abort_se0 || (line == BUS_SE0);
          if (abort_se0 && line == BUS_J) state <= DEC_IDLE;
        end
        default: state <= DEC_IDLE;
      endcase

      if (se0_next == RST_MAX) state <= DEC_IDLE;
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: encodes packets on dp/dn and checks decoded output.
module tb_usb_rx_decoder;
  import usb_rx_pkg::*;

  localparam int RST_CLKS = 200;

  logic clk48 = 1'b0;
  logic reset_n = 1'b0;
  logic dp = 1'b1;
  logic dn = 1'b0;
  logic ls_mode = 1'b0;
  logic bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err;

  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0, n_sop = 0, n_eop = 0, n_stuff = 0, n_se1 = 0;
  bit rx_q[$];
  bus_state_t sym_q[$];

  usb_rx_decoder #(.RESET_CLKS(RST_CLKS)) dut (
    .clk48     (clk48),
    .reset_n   (reset_n),
    .dp        (dp),
    .dn        (dn),
    .ls_mode   (ls_mode),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bus_sop   (bus_sop),
    .bus_eop   (bus_eop),
    .bus_reset (bus_reset),
    .stuff_err (stuff_err),
    .se1_err   (se1_err)
  );

  always #5 clk48 = ~clk48;

  always @(negedge clk48) begin
    if (bit_valid) begin
      n_valid++;
      rx_q.push_back(bit_out);
    end
    if (bus_sop)   n_sop++;
    if (bus_eop)   n_eop++;
    if (stuff_err) n_stuff++;
    if (se1_err)   n_se1++;
  end

  function automatic int jit(input int i);
    case (i % 8)
      0: return 0;
      1: return 3;
      2: return -3;
      3: return 2;
      4: return -1;
      5: return -3;
      6: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bus_state_t flip(input bus_state_t s);
    return (s == BUS_K) ? BUS_J : BUS_K;
  endfunction

  function automatic logic [15:0] rx_word(input int base, input int n);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < n; k++)
      if (base + k < rx_q.size()) w[k] = rx_q[base + k];
    return w;
  endfunction

  function automatic logic [15:0] mask_bits(input logic [15:0] d, input int n);
    logic [15:0] w;
    w = d;
    for (int k = n; k < 16; k++) w[k] = 1'b0;
    return w;
  endfunction

  // Sync KJKJKJKK, NRZI payload LSB first, optional stuffing and SE0 SE0 J.
  task automatic encode(input logic [15:0] data, input int nbits, input bit stuff, input bit eop);
    bus_state_t cur;
    int ones;
    sym_q.delete();
    for (int i = 0; i < 8; i++) sym_q.push_back((i == 7 || i % 2 == 0) ? BUS_K : BUS_J);
    cur = BUS_K;
    ones = 1;
    for (int i = 0; i < nbits; i++) begin
      if (!data[i]) cur = flip(cur);
      sym_q.push_back(cur);
      ones = data[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        cur = flip(cur);
        sym_q.push_back(cur);
        ones = 0;
      end
    end
    if (eop) begin
      sym_q.push_back(BUS_SE0);
      sym_q.push_back(BUS_SE0);
      sym_q.push_back(BUS_J);
    end
  endtask

  task automatic put(input bus_state_t s, input int n);
    case (s)
      BUS_SE0: begin dp = 1'b0; dn = 1'b0; end
      BUS_SE1: begin dp = 1'b1; dn = 1'b1; end
      BUS_J:   begin dp = !ls_mode; dn = ls_mode; end
      default: begin dp = ls_mode; dn = !ls_mode; end
    endcase
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic send(input int from, input int to, input int per, input bit jitter);
    for (int i = from; i < to; i++)
      put(sym_q[i], jitter ? per + jit(i + 1) - jit(i) : per);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk48);
    #1;
    n_checks++;
    if ({bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs %b, want 0000000",
               {bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err});
    end
    reset_n = 1'b1;
    @(posedge clk48);
    #1;
    n_checks++;
    if ({bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_after: outputs %b, want 0000000",
               {bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err});
    end
    put(BUS_J, 12);
  endtask

  task automatic test_fs_packet(input string name, input logic [15:0] data, input int nbits);
    int v0, s0, e0, b0, r0;
    logic [15:0] want;
    v0 = n_valid; s0 = n_sop; e0 = n_eop; b0 = rx_q.size(); r0 = n_stuff + n_se1;
    want = mask_bits(data, nbits);
    encode(data, nbits, 1'b1, 1'b1);
    send(0, sym_q.size(), 4, 1'b0);
    put(BUS_J, 12);
    n_checks++;
    if (n_sop - s0 !== 1) begin
      n_fail++; $display("FAIL %s sop: got %0d want 1", name, n_sop - s0);
    end
    n_checks++;
    if (n_valid - v0 !== nbits) begin
      n_fail++; $display("FAIL %s valid_count: got %0d want %0d", name, n_valid - v0, nbits);
    end
    n_checks++;
    if (rx_word(b0, nbits) !== want) begin
      n_fail++; $display("FAIL %s data: got %h want %h", name, rx_word(b0, nbits), want);
    end
    n_checks++;
    if (n_eop - e0 !== 1) begin
      n_fail++; $display("FAIL %s eop: got %0d want 1", name, n_eop - e0);
    end
    n_checks++;
    if (n_stuff + n_se1 - r0 !== 0) begin
      n_fail++; $display("FAIL %s errors: got %0d want 0", name, n_stuff + n_se1 - r0);
    end
  endtask

  task automatic test_stuff_err();
    int v0, e0, t0, b0;
    v0 = n_valid; e0 = n_eop; t0 = n_stuff; b0 = rx_q.size();
    encode(16'h00FF, 8, 1'b0, 1'b1);
    send(0, sym_q.size(), 4, 1'b0);
    put(BUS_J, 12);
    n_checks++;
    if (n_valid - v0 !== 5) begin
      n_fail++; $display("FAIL stuff_err valid_count: got %0d want 5", n_valid - v0);
    end
    n_checks++;
    if (rx_word(b0, 5) !== 16'h001F) begin
      n_fail++; $display("FAIL stuff_err data: got %h want 001f", rx_word(b0, 5));
    end
    n_checks++;
    if (n_stuff - t0 !== 1) begin
      n_fail++; $display("FAIL stuff_err pulse: got %0d want 1", n_stuff - t0);
    end
    n_checks++;
    if (n_eop - e0 !== 0) begin
      n_fail++; $display("FAIL stuff_err eop: got %0d want 0", n_eop - e0);
    end
  endtask

  task automatic test_ls_jitter();
    int v0, e0, b0;
    ls_mode = 1'b1;
    put(BUS_SE0, 8);
    put(BUS_J, 40);
    v0 = n_valid; e0 = n_eop; b0 = rx_q.size();
    encode(16'h5A3C, 16, 1'b1, 1'b1);
    send(0, sym_q.size(), 32, 1'b1);
    put(BUS_J, 40);
    n_checks++;
    if (n_valid - v0 !== 16) begin
      n_fail++; $display("FAIL ls_jitter valid_count: got %0d want 16", n_valid - v0);
    end
    n_checks++;
    if (rx_word(b0, 16) !== 16'h5A3C) begin
      n_fail++; $display("FAIL ls_jitter data: got %h want 5a3c", rx_word(b0, 16));
    end
    n_checks++;
    if (n_eop - e0 !== 1) begin
      n_fail++; $display("FAIL ls_jitter eop: got %0d want 1", n_eop - e0);
    end
    ls_mode = 1'b0;
    put(BUS_SE0, 8);
    put(BUS_J, 12);
  endtask

  task automatic test_bus_reset();
    dp = 1'b0; dn = 1'b0;
    repeat (RST_CLKS + 1) @(posedge clk48);
    #1;
    n_checks++;
    if (bus_reset !== 1'b0) begin
      n_fail++; $display("FAIL bus_reset_early: got %b want 0", bus_reset);
    end
    @(posedge clk48);
    #1;
    n_checks++;
    if (bus_reset !== 1'b1) begin
      n_fail++; $display("FAIL bus_reset_rise: got %b want 1", bus_reset);
    end
    dp = 1'b1; dn = 1'b0;
    repeat (2) @(posedge clk48);
    #1;
    n_checks++;
    if (bus_reset !== 1'b1) begin
      n_fail++; $display("FAIL bus_reset_hold: got %b want 1", bus_reset);
    end
    @(posedge clk48);
    #1;
    n_checks++;
    if (bus_reset !== 1'b0) begin
      n_fail++; $display("FAIL bus_reset_fall: got %b want 0", bus_reset);
    end
    put(BUS_J, 12);
  endtask

  task automatic test_se1();
    int v0, e0, s0, b0;
    v0 = n_valid; e0 = n_eop; s0 = n_se1; b0 = rx_q.size();
    encode(16'h0000, 3, 1'b1, 1'b0);
    sym_q.push_back(BUS_SE1);
    sym_q.push_back(BUS_SE1);
    sym_q.push_back(BUS_K);
    sym_q.push_back(BUS_J);
    sym_q.push_back(BUS_K);
    sym_q.push_back(BUS_J);
    sym_q.push_back(BUS_SE0);
    sym_q.push_back(BUS_SE0);
    sym_q.push_back(BUS_J);
    send(0, sym_q.size(), 4, 1'b0);
    put(BUS_J, 12);
    n_checks++;
    if (n_valid - v0 !== 3) begin
      n_fail++; $display("FAIL se1 valid_count: got %0d want 3", n_valid - v0);
    end
    n_checks++;
    if (rx_word(b0, 3) !== 16'h0000) begin
      n_fail++; $display("FAIL se1 data: got %h want 0000", rx_word(b0, 3));
    end
    n_checks++;
    if (n_se1 - s0 !== 1) begin
      n_fail++; $display("FAIL se1 pulse: got %0d want 1", n_se1 - s0);
    end
    n_checks++;
    if (n_eop - e0 !== 0) begin
      n_fail++; $display("FAIL se1 eop: got %0d want 0", n_eop - e0);
    end
  endtask

  task automatic test_mid_reset();
    int v0, e0;
    encode(16'h0000, 8, 1'b1, 1'b1);
    send(0, 12, 4, 1'b0);
    reset_n = 1'b0;
    #2;
    n_checks++;
    if ({bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: outputs %b, want 0000000",
               {bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err});
    end
    @(posedge clk48);
    #1;
    reset_n = 1'b1;
    @(posedge clk48);
    #1;
    n_checks++;
    if ({bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_reset_after: outputs %b, want 0000000",
               {bit_out, bit_valid, bus_sop, bus_eop, bus_reset, stuff_err, se1_err});
    end
    v0 = n_valid; e0 = n_eop;
    send(12, sym_q.size(), 4, 1'b0);
    put(BUS_J, 12);
    n_checks++;
    if (n_valid - v0 !== 0) begin
      n_fail++; $display("FAIL mid_reset valid_count: got %0d want 0", n_valid - v0);
    end
    n_checks++;
    if (n_eop - e0 !== 0) begin
      n_fail++; $display("FAIL mid_reset eop: got %0d want 0", n_eop - e0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0, b0;
    v0 = n_valid; e0 = n_eop; b0 = rx_q.size();
    encode(16'h00A5, 8, 1'b1, 1'b1);
    send(0, sym_q.size(), 4, 1'b0);
    encode(16'h00C3, 8, 1'b1, 1'b1);
    send(0, sym_q.size(), 4, 1'b0);
    put(BUS_J, 12);
    n_checks++;
    if (n_valid - v0 !== 16) begin
      n_fail++; $display("FAIL b2b valid_count: got %0d want 16", n_valid - v0);
    end
    n_checks++;
    if (rx_word(b0, 16) !== 16'hC3A5) begin
      n_fail++; $display("FAIL b2b data: got %h want c3a5", rx_word(b0, 16));
    end
    n_checks++;
    if (n_eop - e0 !== 2) begin
      n_fail++; $display("FAIL b2b eop: got %0d want 2", n_eop - e0);
    end
  endtask

  initial begin
    test_reset();
    test_fs_packet("fs_zero", 16'h0000, 8);
    test_fs_packet("fs_ones", 16'h00FF, 8);
    test_fs_packet("fs_mixed", 16'h7E3F, 16);
    test_stuff_err();
    test_ls_jitter();
    test_fs_packet("fs_after_ls", 16'h00A5, 8);
    test_bus_reset();
    test_se1();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_decoder.md
USB_RX_DECODER -- requirements
Module: usb_rx_decoder

Interface
REQ-001 Parameter OVS_FS, default 4: clk48 cycles per full-speed bit; minimum 4.
REQ-002 Parameter OVS_LS, default 32: clk48 cycles per low-speed bit; minimum 4.
REQ-003 Parameter STUFF_LEN, default 6: consecutive ones after which one stuffed zero is removed.
REQ-004 Parameter RESET_CLKS, default 360000: SE0 cycles needed to flag a bus reset.
REQ-005 Parameter SYNC_STAGES, default 2: synchronizer flops on dp/dn; minimum 2.
REQ-006 clk48  input  1  single clock for all logic.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 dp, dn  input  1 each  raw asynchronous line inputs.
REQ-009 ls_mode  input  1  1 = low-speed (J = dn high, period OVS_LS); 0 = full-speed (J = dp high, period OVS_FS); sampled only in IDLE.
REQ-010 bit_out  output  1  decoded NRZI bit, 1 = no transition.
REQ-011 bit_valid  output  1  one-cycle strobe per unstuffed payload bit.
REQ-012 bus_sop, bus_eop, bus_reset, stuff_err, se1_err  output  1 each  status (Function).

Function
REQ-013 dp/dn pass through SYNC_STAGES flops, then classify: 00 SE0, J, K, 11 SE1 (J/K polarity per latched ls_mode).
REQ-014 Phase counter P = 0..period-1; any J<->K change on the synchronized line reloads P to 0 (edge resync) in every state except IDLE.
REQ-015 Bit value = majority of line samples at P = period/2-1, period/2, period/2+1; decision made at P = period/2+1.
REQ-016 States: IDLE, SYNC, PAYLOAD, EOP, ABORT.
REQ-017 IDLE -> SYNC on first synchronized K; bus_sop pulses 1 cycle on that transition; P reloads to 0.
REQ-018 SYNC -> PAYLOAD when two consecutive decided bit symbols are K; SYNC bits produce no bit_valid.
REQ-019 PAYLOAD: bit_out = (symbol == previous symbol); bit_valid pulses 1 cycle after the decision cycle unless the bit is a stuffed zero.
REQ-020 Stuff counter counts consecutive ones from SYNC's final KK onward; after STUFF_LEN ones the next bit, if 0, is dropped and counter clears; if 1, stuff_err pulses and state -> ABORT.
REQ-021 PAYLOAD: decided SE0 -> EOP, no bit_valid for it; decided SE1 -> se1_err pulse, state -> ABORT.
REQ-022 EOP -> IDLE on first synchronized J; bus_eop pulses 1 cycle on that transition; K in EOP -> ABORT.
REQ-023 ABORT -> IDLE after SE0 followed by J, no bus_eop.
REQ-024 bus_reset = 1 while synchronized SE0 has lasted >= RESET_CLKS cycles (saturating counter, cleared by non-SE0); independent of state; forces state to IDLE.
REQ-025 Simultaneous edge resync and decision point: resync wins, no decision that cycle.
REQ-026 Counter widths via $clog2 of parameters; no truncation at maxima.

Reset
REQ-027 reset_n low: state IDLE, P = 0, synchronizers/vote/stuff/SE0 counters 0, latched mode = full-speed.
REQ-028 All outputs 0 during and in the cycle after reset; reset mid-packet drops it without bus_eop.

Structure
REQ-029 Package usb_rx_pkg holds BusState (SE0,J,K,SE1) and DecoderState enums plus default period/stuff constants.
REQ-030 Sub-module usb_line_sync: synchronizer and line classification (REQ-013); the rest is in usb_rx_decoder.

Verification
REQ-031 FS, period 4: SYNC KJKJKJKK then payload 0x00 LSB-first, SE0 2 bits, J -> bus_sop once, 8 bit_valid with bit_out 0, bus_eop once.
REQ-032 FS payload 0xFF (eight ones): stuffed zero after 6th one -> exactly 8 bit_valid all 1; removing stuff bit -> stuff_err, no bus_eop.
REQ-033 LS mode, period 32, data edges jittered +/-3 cycles -> all bits decoded correctly via resync/vote.
REQ-034 SE0 held 360000 cycles -> bus_reset rises on cycle 360000 (after sync latency), falls 1 cycle after first J.
REQ-035 SE1 mid-payload -> se1_err pulse, no further bit_valid, no bus_eop; reset_n pulsed mid-packet -> all outputs 0, state IDLE.
